ssram_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single-port SSRAM Wishbone slave between the instruction-fetch port (m0) and the load/store port (m1). It grants one master at a time with round-robin fairness and forwards its cycle unchanged to the slave. Between transfers it inserts one idle slave cycle so every slave request starts on a fresh stb rising edge. A watchdog terminates any transfer the slave fails to acknowledge and returns an error to the owning master.

---
 rtl/ssram_arbiter.sv | 126 ++++++++++++
 tb/tb_ssram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssram_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the single-port SSRAM slave.
// Ports: clk_i/rst_ni, masters m0_*/m1_* (cyc,stb,we,sel,addr,data,ack,err), slave s_*.
module ssram_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_data_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_data_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  wd_q, wd_d;

  logic        req0, req1, req_g, tmo;
  logic        ack, err;

  assign req0  = m0_cyc_i & m0_stb_i;
  assign req1  = m1_cyc_i & m1_stb_i;
  assign req_g = grant_q ? req1 : req0;
  assign tmo   = (wd_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wd_d     = wd_q;
    ack      = 1'b0;
    err      = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'd0;
    s_addr_o = 32'd0;
    s_data_o = 32'd0;
    case (state_q)
      IDLE, GAP: begin
        if (req0 | req1) begin
          // On a tie the master that was not served last wins.
          grant_d = (req0 & req1) ? ~last_q : req1;
          state_d = BUSY;
          wd_d    = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        s_cyc_o  = 1'b1;
        s_stb_o  = 1'b1;
        s_we_o   = grant_q ? m1_we_i   : m0_we_i;
        s_sel_o  = grant_q ? m1_sel_i  : m0_sel_i;
        s_addr_o = grant_q ? m1_addr_i : m0_addr_i;
        s_data_o = grant_q ? m1_data_i : m0_data_i;
        ack      = s_ack_i;
        if (s_ack_i) begin
          state_d = GAP;
          last_d  = grant_q;
        end else if (!req_g) begin
          state_d = GAP;
          last_d  = grant_q;
        end else if (tmo) begin
          err     = 1'b1;
          state_d = GAP;
          last_d  = grant_q;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_ack_o  = ack & ~grant_q;
  assign m1_ack_o  = ack &  grant_q;
  assign m0_err_o  = err & ~grant_q;
  assign m1_err_o  = err &  grant_q;
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

endmodule

// File: tb/tb_ssram_arbiter.sv
// Bench for ssram_arbiter: directed tables, corner sequences, random traffic.
// Includes a two-cycle registered SSRAM slave with a switchable ack.
module tb_ssram_arbiter;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        cyc[2], stb[2], we[2];
  logic [3:0]  sel[2];
  logic [31:0] adr[2], wd[2];
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_data_o;
  logic        s_ack_i;
  logic [31:0] sdat;
  logic        d1;
  logic        sl_en;

  ssram_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
    .m0_sel_i(sel[0]), .m0_addr_i(adr[0]), .m0_data_i(wd[0]),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_data_o(m0_data_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
    .m1_sel_i(sel[1]), .m1_addr_i(adr[1]), .m1_data_i(wd[1]),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_data_o(m1_data_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_ack_i(s_ack_i), .s_data_i(sdat)
  );

  // SSRAM slave: ack visible two cycles after stb rises.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      d1      <= 1'b0;
      s_ack_i <= 1'b0;
    end else begin
      d1      <= s_stb_o & ~d1 & ~s_ack_i;
      s_ack_i <= s_stb_o & d1 & sl_en;
    end
  end

  typedef struct {
    bit          r0, r1;
    bit          stb;
    logic [31:0] addr;
    bit          a0, a1;
  } vec_t;
  vec_t tbl[16];

  int npass = 0;
  int ncheck = 0;
  // Reference model: current owner (-1 none), cycles spent owning, last served.
  int own = -1;
  int blen = 0;
  int lst = 1;
  bit e_ack[2], e_err[2];
  bit active[2];

  function automatic vec_t mk(bit s, logic [31:0] a, bit a0, bit a1);
    vec_t v;
    v.r0 = 1'b1; v.r1 = 1'b1;
    v.stb = s; v.addr = a; v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    ncheck++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic check();
    logic [74:0] ev, gv;
    bit rq[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      rq[k] = cyc[k] & stb[k];
      e_ack[k] = 1'b0;
      e_err[k] = 1'b0;
    end
    ev = '0;
    if (own >= 0) begin
      e_ack[own] = s_ack_i;
      e_err[own] = !s_ack_i && rq[own] && (blen == TO - 1);
      ev = {2'b11, we[own], sel[own], adr[own], wd[own],
            e_ack[0], e_err[0], e_ack[1], e_err[1]};
    end
    gv = {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
    chk("outputs", gv, ev);
    chk("rdata", {m0_data_o, m1_data_o}, {sdat, sdat});
  endtask

  task automatic adv();
    bit rq[2];
    for (int k = 0; k < 2; k++) rq[k] = cyc[k] & stb[k];
    if (own >= 0) begin
      if (s_ack_i || !rq[own] || blen == TO - 1) begin
        lst = own;
        own = -1;
      end else begin
        blen++;
      end
    end else if (rq[0] || rq[1]) begin
      own = (rq[0] && rq[1]) ? 1 - lst : (rq[1] ? 1 : 0);
      blen = 0;
    end
    @(posedge clk);
    #1;
    sdat = $urandom;
  endtask

  task automatic tick();
    check();
    adv();
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      sel[k] = 4'd0; adr[k] = 32'd0; wd[k] = 32'd0;
      active[k] = 1'b0;
    end
  endtask

  task automatic set_m(input int k, input bit w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w;
    sel[k] = s; adr[k] = a; wd[k] = d;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("reset_outs", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o,
        s_data_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, '0);
    own = -1; blen = 0; lst = 1;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    sdat = $urandom;
  endtask

  task automatic wait_ack(input int k, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      check();
      seen = (k == 1) ? m1_ack_o : m0_ack_o;
      adv();
    end
    chk(nm, seen, 1'b1);
    idle();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(0, 32'h0, 0, 0);
    tbl[1]  = mk(1, 32'h1000, 0, 0);
    tbl[2]  = mk(1, 32'h1000, 0, 0);
    tbl[3]  = mk(1, 32'h1000, 1, 0);
    tbl[4]  = mk(0, 32'h0, 0, 0);
    tbl[5]  = mk(1, 32'h2000, 0, 0);
    tbl[6]  = mk(1, 32'h2000, 0, 0);
    tbl[7]  = mk(1, 32'h2000, 0, 1);
    tbl[8]  = mk(0, 32'h0, 0, 0);
    tbl[9]  = mk(1, 32'h1000, 0, 0);
    tbl[10] = mk(1, 32'h1000, 0, 0);
    tbl[11] = mk(1, 32'h1000, 1, 0);
    tbl[12] = mk(0, 32'h0, 0, 0);
    tbl[13] = mk(1, 32'h2000, 0, 0);
    tbl[14] = mk(1, 32'h2000, 0, 0);
    tbl[15] = mk(1, 32'h2000, 0, 1);

    idle();
    sl_en = 1'b1;
    sdat = 32'h0;

    // m0 reads 0x100 alone after reset
    do_reset();
    set_m(0, 1'b0, 4'hf, 32'h100, 32'h0);
    check(); chk("t1_idle", s_stb_o, 1'b0); adv();
    check(); chk("t1_stb", {s_stb_o, s_addr_o}, {1'b1, 32'h100}); adv();
    tick();
    check(); chk("t1_ack", {s_ack_i, m0_ack_o, m1_ack_o}, 3'b110); adv();
    idle();
    check(); chk("t1_gap", {s_stb_o, m0_ack_o}, 2'b00); adv();

    // both masters persistent from reset
    do_reset();
    set_m(0, 1'b0, 4'hf, 32'h1000, 32'h0);
    set_m(1, 1'b0, 4'hf, 32'h2000, 32'h0);
    for (int i = 0; i < 16; i++) begin
      cyc[0] = tbl[i].r0; stb[0] = tbl[i].r0;
      cyc[1] = tbl[i].r1; stb[1] = tbl[i].r1;
      check();
      chk($sformatf("tbl%0d", i),
          {s_stb_o, s_addr_o, m0_ack_o, m1_ack_o},
          {tbl[i].stb, tbl[i].addr, tbl[i].a0, tbl[i].a1});
      adv();
    end
    idle();
    tick();

    // m1 write alone
    set_m(1, 1'b1, 4'h3, 32'h40, 32'hDEADBEEF);
    tick();
    check();
    chk("wr_fields", {s_we_o, s_sel_o, s_data_o, s_addr_o},
        {1'b1, 4'h3, 32'hDEADBEEF, 32'h40});
    adv();
    tick();
    check(); chk("wr_ack", {m0_ack_o, m1_ack_o}, 2'b01); adv();
    idle();
    tick();

    // watchdog on m0, m1 pending
    sl_en = 1'b0;
    set_m(0, 1'b0, 4'hf, 32'h300, 32'h0);
    tick();
    set_m(1, 1'b0, 4'hf, 32'h400, 32'h0);
    for (int i = 1; i < TO; i++) begin
      check();
      if (i == TO - 1) chk("to_early", m0_err_o, 1'b0);
      adv();
    end
    check(); chk("to_err", {m0_err_o, m1_err_o, s_stb_o}, 3'b101); adv();
    check(); chk("to_gap", s_stb_o, 1'b0); adv();
    cyc[0] = 1'b0; stb[0] = 1'b0;
    sl_en = 1'b1;
    check(); chk("to_m1", {s_stb_o, s_addr_o}, {1'b1, 32'h400}); adv();
    wait_ack(1, "to_m1_ack");

    // m0 abandons in its first BUSY cycle
    set_m(0, 1'b0, 4'hf, 32'h500, 32'h0);
    tick();
    set_m(1, 1'b0, 4'hf, 32'h600, 32'h0);
    cyc[0] = 1'b0;
    check(); chk("drop_busy", {m0_ack_o, m0_err_o, s_stb_o}, 3'b001); adv();
    check(); chk("drop_gap", s_stb_o, 1'b0); adv();
    check(); chk("drop_m1", {s_stb_o, s_addr_o}, {1'b1, 32'h600}); adv();
    wait_ack(1, "drop_m1_ack");

    // reset mid-BUSY, tie afterwards goes to m0
    set_m(0, 1'b0, 4'hf, 32'h700, 32'h0);
    set_m(1, 1'b0, 4'hf, 32'h800, 32'h0);
    tick();
    check();
    do_reset();
    tick();
    check(); chk("rst_m0_first", {s_stb_o, s_addr_o}, {1'b1, 32'h700}); adv();
    wait_ack(0, "rst_m0_ack");

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) sl_en = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        if (active[k] && (e_ack[k] || e_err[k] || $urandom_range(0, 49) == 0)) begin
          cyc[k] = 1'b0; stb[k] = 1'b0; active[k] = 1'b0;
        end else if (!active[k] && $urandom_range(0, 2) == 0) begin
          set_m(k, 1'($urandom), 4'($urandom), $urandom, $urandom);
          active[k] = 1'b1;
        end
      end
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
